// File: rtl/l2_fill_responder.sv
// L2 side of the L1 line-address interface: request FIFO, direct-mapped
// tag lookup, hit/miss latency and statistics counters.
module l2_fill_responder #(
  parameter int FIFO_DEPTH = 4,
  parameter int L2_IDX_W   = 8,
  parameter int HIT_LAT    = 2,
  parameter int MISS_LAT   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [25:0] req_addr,
  input  logic        req_write,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [25:0] rsp_addr,
  output logic        rsp_write,
  output logic        rsp_hit,
  input  logic        rsp_ready,
  input  logic        flush,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int TAG_W = 26 - L2_IDX_W;
  localparam int LINES = 1 << L2_IDX_W;
  localparam int LMAX  = (HIT_LAT > MISS_LAT) ? HIT_LAT : MISS_LAT;
  localparam int CW    = (LMAX < 2) ? 1 : $clog2(LMAX);

  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] HIT_C   = CW'(HIT_LAT - 1);
  localparam logic [CW-1:0] MISS_C  = CW'(MISS_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [26:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop;

  logic [TAG_W-1:0] tag_mem [LINES];
  logic [LINES-1:0] valid_q;

  logic [25:0]         work_addr;
  logic                work_write;
  logic                hit_q;
  logic [L2_IDX_W-1:0] idx;
  logic [TAG_W-1:0]    wtag;
  logic                lookup_hit;
  logic                install;

  assign req_ready = rst_n & (count < DEPTH_C);
  assign push      = req_valid & req_ready;
  assign pop       = (state_q == IDLE) & (count != '0);

  assign idx        = work_addr[L2_IDX_W-1:0];
  assign wtag       = work_addr[25:L2_IDX_W];
  assign lookup_hit = valid_q[idx] & (tag_mem[idx] == wtag) & ~flush;
  assign install    = (state_q == LOOKUP) & ~lookup_hit & ~flush;

  assign rsp_valid = (state_q == RESP);
  assign rsp_addr  = work_addr;
  assign rsp_write = work_write;
  assign rsp_hit   = hit_q;

  // FIFO storage, written on an accepted request
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_write, req_addr};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Tag array, written when a miss allocates a line
  always_ff @(posedge clk) begin
    if (install) tag_mem[idx] <= wtag;
  end

  // Valid bits: flush wins over a same-edge allocation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (install) begin
      valid_q[idx] <= 1'b1;
    end
  end

  // FSM, latency counter, work register and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_addr  <= '0;
      work_write <= 1'b0;
      hit_q      <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (pop) begin
        {work_write, work_addr} <= fifo_mem[rd_ptr];
      end
      if (state_q == LOOKUP) begin
        hit_q <= lookup_hit;
        if (lookup_hit) hit_cnt  <= hit_cnt + 32'd1;
        else            miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  // Next-state and latency countdown
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (count != '0) state_d = LOOKUP;
      end
      LOOKUP: begin
        state_d = WAIT;
        cnt_d   = lookup_hit ? HIT_C : MISS_C;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_fill_responder.sv
// Scoreboard bench for l2_fill_responder: a line-level cache model
// predicts each response, a monitor checks responses as they retire.
module tb_l2_fill_responder;

  localparam int HIT_LAT  = 2;
  localparam int MISS_LAT = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [25:0] req_addr = '0;
  logic        req_write = 1'b0;
  logic        req_ready;
  logic        rsp_valid;
  logic [25:0] rsp_addr;
  logic        rsp_write;
  logic        rsp_hit;
  logic        rsp_ready = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  l2_fill_responder #(
    .FIFO_DEPTH(4),
    .L2_IDX_W(8),
    .HIT_LAT(HIT_LAT),
    .MISS_LAT(MISS_LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_write(req_write),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_addr(rsp_addr),
    .rsp_write(rsp_write),
    .rsp_hit(rsp_hit),
    .rsp_ready(rsp_ready),
    .flush(flush),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [25:0] addr;
    logic        wr;
    logic        hit;
    int unsigned hc;
    int unsigned mc;
    bit          chk_lat;
    int          k;
    int          lat;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // reference: which line address each L2 set currently holds
  bit          mvalid [256];
  logic [25:0] mline  [256];
  int unsigned mh = 0;
  int unsigned mm = 0;
  bit          rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
  endtask

  task automatic model_push(input logic [25:0] a, input logic w,
                            input bit force_miss, input bit chk,
                            input int k);
    exp_t e;
    int   s;
    bit   h;
    s = int'(a % 256);
    h = !force_miss && mvalid[s] && (mline[s] == a);
    if (h) mh++;
    else   mm++;
    if (!h && !force_miss) begin
      mvalid[s] = 1'b1;
      mline[s]  = a;
    end
    e.addr    = a;
    e.wr      = w;
    e.hit     = h;
    e.hc      = mh;
    e.mc      = mm;
    e.chk_lat = chk;
    e.k       = k;
    e.lat     = h ? HIT_LAT : MISS_LAT;
    sbq.push_back(e);
  endtask

  task automatic push(input logic [25:0] a, input logic w,
                      input bit force_miss, input bit chk);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout addr=%0h ready=%0b required=1", a, req_ready);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      model_push(a, w, force_miss, chk, cyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
      sbq.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1;
    rsp_ready = v;
  endtask

  task automatic flush_pulse();
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_clear();
  endtask

  always @(posedge clk) begin
    #2;
    if (rand_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // monitor: retire one expected entry per accepted response
  bit seen = 1'b0;
  int start = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      seen = 1'b0;
    end else if (rsp_valid) begin
      if (!seen) begin
        seen  = 1'b1;
        start = cyc;
      end
      if (rsp_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp addr=%0h required=none", rsp_addr);
        end else begin
          e = sbq.pop_front();
          check("rsp_addr", 64'(rsp_addr), 64'(e.addr));
          check("rsp_write", 64'(rsp_write), 64'(e.wr));
          check("rsp_hit", 64'(rsp_hit), 64'(e.hit));
          check("hit_cnt", 64'(hit_cnt), 64'(e.hc));
          check("miss_cnt", 64'(miss_cnt), 64'(e.mc));
          if (e.chk_lat)
            check("latency", 64'(start - e.k), 64'(2 + e.lat));
        end
        seen = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [25:0] a;
    model_clear();
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_addr", 64'(rsp_addr), 64'd0);
    check("rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'd1);
    set_rdy(1'b1);

    push(26'h0001234, 1'b0, 1'b0, 1'b1);
    drain();
    push(26'h0001234, 1'b0, 1'b0, 1'b1);
    drain();

    push(26'h0000134, 1'b0, 1'b0, 1'b0);
    push(26'h0000234, 1'b1, 1'b0, 1'b0);
    push(26'h0000134, 1'b0, 1'b0, 1'b0);
    drain();

    set_rdy(1'b0);
    for (int i = 0; i < 5; i++)
      push(26'h0000040 + 26'(i), 1'(i & 1), 1'b0, 1'b0);
    check("full_ready", 64'(req_ready), 64'd0);
    repeat (15) @(posedge clk);
    #1;
    check("full_ready_held", 64'(req_ready), 64'd0);
    set_rdy(1'b1);
    drain();

    push(26'h0001234, 1'b0, 1'b0, 1'b0);
    drain();
    flush_pulse();
    push(26'h0001234, 1'b0, 1'b0, 1'b1);
    drain();
    push(26'h0001234, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_clear();
    drain();
    push(26'h0001234, 1'b0, 1'b0, 1'b1);
    drain();
    push(26'h0001234, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_clear();
    drain();
    push(26'h0001234, 1'b0, 1'b0, 1'b1);
    drain();

    push(26'h00ABCDE, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    check("mid_rst_hit_cnt", 64'(hit_cnt), 64'd0);
    check("mid_rst_miss_cnt", 64'(miss_cnt), 64'd0);
    sbq.delete();
    model_clear();
    mh = 0;
    mm = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_release_ready", 64'(req_ready), 64'd1);
    push(26'h0001234, 1'b0, 1'b0, 1'b1);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        drain();
        flush_pulse();
      end
      a = {18'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
      push(a, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    drain();
    rand_rdy = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
